// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM signal bundle for sram_port_arbiter.
// slave: arbiter side; master: requesters plus SRAM side.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_gnt, inst_rvalid, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_gnt, inst_rvalid, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between an
// instruction and a data requester, data first with anti-starvation.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               resetn,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} owner_t;

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       wr_q;
  logic       inst_win;
  logic       data_win;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Gating with resetn keeps every grant and SRAM strobe low in reset.
  always_comb begin
    inst_win = resetn && bus.inst_req &&
               (!bus.data_req || starve_cnt == LIMIT);
    data_win = resetn && bus.data_req && !inst_win;
  end

  assign bus.inst_gnt = inst_win;
  assign bus.data_gnt = data_win;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'h0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    unique case (1'b1)
      inst_win: begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = bus.inst_addr;
      end
      data_win: begin
        bus.sram_en    = 1'b1;
        bus.sram_wen   = bus.data_wen;
        bus.sram_addr  = bus.data_addr;
        bus.sram_wdata = bus.data_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.inst_rvalid = (owner == RESP_I);
    bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : 32'h0;
    bus.data_rvalid = (owner == RESP_D);
    bus.data_rdata  = (bus.data_rvalid && !wr_q) ?
                      bus.sram_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= IDLE;
      starve_cnt <= 4'h0;
      wr_q       <= 1'b0;
    end else begin
      unique case (1'b1)
        inst_win: owner <= RESP_I;
        data_win: owner <= RESP_D;
        default:  owner <= IDLE;
      endcase
      wr_q <= data_win && (|bus.data_wen);
      if (!bus.inst_req || inst_win)
        starve_cnt <= 4'h0;
      else if (data_win && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'h1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM.
// Expected responses are queued at grant time and popped on rvalid.
module tb_sram_port_arbiter;

  typedef struct packed {
    logic        inst;
    logic [31:0] d;
  } exp_t;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [31:0] mem [logic [31:0]];

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h1FC0_0000) ? 32'h3C08_BFAF : (a ^ 32'hC0DE_0000);
  endfunction

  // Synchronous SRAM: read data valid the cycle after sram_en.
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.sram_en) begin
      w = mem.exists(bus.sram_addr) ? mem[bus.sram_addr]
                                    : init_word(bus.sram_addr);
      bus.sram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (bus.sram_wen[b]) w[8*b +: 8] = bus.sram_wdata[8*b +: 8];
      if (bus.sram_wen != 4'h0) mem[bus.sram_addr] = w;
    end
  end

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'h0;
    bus.data_req   = 1'b0;
    bus.data_wen   = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [33:0] got, want;
    resetn = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1FC0_0000;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_4000;
    #2;
    checks++;
    if ({bus.inst_gnt, bus.data_gnt, bus.sram_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_gnt got %b%b en %b want 000",
               bus.inst_gnt, bus.data_gnt, bus.sram_en);
    end
    checks++;
    if ({bus.sram_addr, bus.sram_wdata, bus.sram_wen} !== 68'h0) begin
      errors++;
      $display("FAIL reset_sram addr %h wdata %h wen %h want 0",
               bus.sram_addr, bus.sram_wdata, bus.sram_wen);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata,
         bus.data_rdata, dut.starve_cnt} !== 70'h0) begin
      errors++;
      $display("FAIL reset_resp rv %b%b rdata %h %h cnt %0d want 0",
               bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata,
               bus.data_rdata, dut.starve_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    bus.data_req = 1'b0;
    #1;
    checks++;
    if (bus.inst_gnt !== 1'b1) begin
      errors++;
      $display("FAIL first_gnt got %b want 1", bus.inst_gnt);
    end
    q.push_back('{1'b1, 32'h3C08_BFAF});
    @(negedge clk);
    e = q.pop_front();
    got  = {bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata};
    want = {e.inst, !e.inst, e.d};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL first_resp got %h want %h", got, want);
    end
    idle_inputs();
  endtask

  task automatic test_inst_only();
    exp_t e;
    logic [33:0] got, want;
    logic [31:0] a;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got  = {bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata};
        want = {e.inst, !e.inst, e.d};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL fetch_resp%0d got %h want %h", i, got, want);
        end
      end
      if (i == 5) begin
        idle_inputs();
      end else begin
        a = 32'h1FC0_0000 + 32'(4 * i);
        bus.inst_req  = 1'b1;
        bus.inst_addr = a;
        #1;
        checks++;
        if ({bus.inst_gnt, bus.data_gnt, bus.sram_en, bus.sram_addr,
             bus.sram_wen, bus.sram_wdata} !==
            {3'b101, a, 4'h0, 32'h0}) begin
          errors++;
          $display("FAIL fetch_gnt%0d gnt %b%b en %b addr %h want addr %h",
                   i, bus.inst_gnt, bus.data_gnt, bus.sram_en,
                   bus.sram_addr, a);
        end
        q.push_back('{1'b1, init_word(a)});
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    logic [33:0] got, want;
    @(negedge clk);
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1FC0_0020;
    bus.data_req  = 1'b1;
    bus.data_wen  = 4'h0;
    bus.data_addr = 32'h0000_1000;
    #1;
    checks++;
    if ({bus.inst_gnt, bus.data_gnt, bus.sram_addr} !==
        {2'b01, 32'h0000_1000}) begin
      errors++;
      $display("FAIL coll_gnt gnt %b%b addr %h want 01 00001000",
               bus.inst_gnt, bus.data_gnt, bus.sram_addr);
    end
    q.push_back('{1'b0, init_word(32'h0000_1000)});
    @(negedge clk);
    e = q.pop_front();
    got  = {bus.inst_rvalid, bus.data_rvalid, bus.data_rdata};
    want = {e.inst, !e.inst, e.d};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL coll_dresp got %h want %h", got, want);
    end
    bus.data_req = 1'b0;
    #1;
    checks++;
    if ({bus.inst_gnt, bus.data_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL coll_igrant got %b%b want 10",
               bus.inst_gnt, bus.data_gnt);
    end
    q.push_back('{1'b1, init_word(32'h1FC0_0020)});
    @(negedge clk);
    e = q.pop_front();
    got  = {bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata};
    want = {e.inst, !e.inst, e.d};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL coll_iresp got %h want %h", got, want);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    exp_t e;
    logic [33:0] got, want;
    logic [3:0]  m_cnt = 4'h0;
    logic        exp_i;
    @(negedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got  = {bus.inst_rvalid, bus.data_rvalid,
                e.inst ? bus.inst_rdata : bus.data_rdata};
        want = {e.inst, !e.inst, e.d};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL starve_resp%0d got %h want %h", k, got, want);
        end
      end
      checks++;
      if (dut.starve_cnt !== m_cnt) begin
        errors++;
        $display("FAIL starve_cnt%0d got %0d want %0d",
                 k, dut.starve_cnt, m_cnt);
      end
      if (k == 10) begin
        idle_inputs();
      end else begin
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1FC0_0040;
        bus.data_req  = 1'b1;
        bus.data_wen  = 4'h0;
        bus.data_addr = 32'h0000_3000;
        #1;
        exp_i = (m_cnt == 4'(LIM));
        checks++;
        if ({bus.inst_gnt, bus.data_gnt} !== {exp_i, !exp_i}) begin
          errors++;
          $display("FAIL starve_gnt%0d got %b%b want %b%b", k,
                   bus.inst_gnt, bus.data_gnt, exp_i, !exp_i);
        end
        q.push_back(exp_i ? '{1'b1, init_word(32'h1FC0_0040)}
                          : '{1'b0, init_word(32'h0000_3000)});
        m_cnt = exp_i ? 4'h0 : m_cnt + 4'h1;
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [33:0] got, want;
    logic [3:0]  wens [3] = '{4'hF, 4'h3, 4'h0};
    logic [31:0] wd   [3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0};
    logic [31:0] rd   [3] = '{32'h0, 32'h0, 32'h1122_CCDD};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got  = {bus.inst_rvalid, bus.data_rvalid, bus.data_rdata};
        want = {e.inst, !e.inst, e.d};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL wr_resp%0d got %h want %h", k, got, want);
        end
      end
      if (k == 3) begin
        idle_inputs();
      end else begin
        bus.data_req   = 1'b1;
        bus.data_wen   = wens[k];
        bus.data_wdata = wd[k];
        bus.data_addr  = 32'h0000_2000;
        #1;
        checks++;
        if ({bus.data_gnt, bus.sram_en, bus.sram_wen, bus.sram_wdata,
             bus.sram_addr} !== {2'b11, wens[k], wd[k], 32'h2000}) begin
          errors++;
          $display("FAIL wr_sram%0d gnt %b en %b wen %h wdata %h addr %h",
                   k, bus.data_gnt, bus.sram_en, bus.sram_wen,
                   bus.sram_wdata, bus.sram_addr);
        end
        q.push_back('{1'b0, rd[k]});
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [33:0] got, want;
    @(negedge clk);
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1FC0_0030;
    #1;
    checks++;
    if (bus.inst_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rm_gnt got %b want 1", bus.inst_gnt);
    end
    q.push_back('{1'b1, init_word(32'h1FC0_0030)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    got  = {bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata};
    want = {e.inst, !e.inst, e.d};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rm_resp got %h want %h", got, want);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.inst_gnt, bus.data_gnt, bus.inst_rvalid, bus.data_rvalid,
         bus.sram_en, bus.inst_rdata, bus.sram_addr} !== 69'h0) begin
      errors++;
      $display("FAIL rm_async gnt %b rv %b en %b rdata %h addr %h",
               bus.inst_gnt, bus.inst_rvalid, bus.sram_en,
               bus.inst_rdata, bus.sram_addr);
    end
    q.delete();
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.inst_rvalid, bus.data_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL rm_ghost%0d rv %b%b want 00",
                 k, bus.inst_rvalid, bus.data_rvalid);
      end
    end
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.sram_en, bus.inst_gnt, bus.data_gnt, bus.inst_rvalid,
           bus.data_rvalid, dut.starve_cnt} !== 9'h0) begin
        errors++;
        $display("FAIL idle%0d en %b gnt %b%b rv %b%b cnt %0d", k,
                 bus.sram_en, bus.inst_gnt, bus.data_gnt,
                 bus.inst_rvalid, bus.data_rvalid, dut.starve_cnt);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_inst_only();
    test_collision();
    test_starvation();
    test_write_read();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The parameter list SHALL be: STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits (range 1..15).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port resetn, input, 1 bit, SHALL be reset: asynchronous assertion, active-low, released synchronously by the integrator.
REQ-004 Instruction requester ports SHALL be: inst_req in 1, fetch request; inst_addr in 32, physical address; inst_gnt out 1, request accepted this cycle; inst_rvalid out 1, inst_rdata valid; inst_rdata out 32, fetched word.
REQ-005 Data requester ports SHALL be: data_req in 1, access request; data_wen in 4, byte write enables (0 = read); data_addr in 32; data_wdata in 32; data_gnt out 1; data_rvalid out 1, completion (read or write); data_rdata out 32.
REQ-006 Shared SRAM ports SHALL be: sram_en out 1; sram_wen out 4; sram_addr out 32; sram_wdata out 32; sram_rdata in 32, valid the cycle after sram_en.

Function
REQ-007 The block SHALL share one single-ported synchronous SRAM between the two requesters, one access per cycle.
REQ-008 The requester SHALL hold req, addr, wen, wdata stable until it sees its gnt high; gnt is a combinational same-cycle accept.
REQ-009 At most one gnt SHALL be high per cycle; gnt is never high when the matching req is low.
REQ-010 Grant priority SHALL be data over instruction, except instruction wins when inst_req=1 and starve_cnt == STARVE_LIMIT.
REQ-011 On a granted cycle, sram_en=1 and sram_addr/sram_wen/sram_wdata SHALL equal the granted requester's inputs (sram_wen=0, sram_wdata=0 for instruction grants).
REQ-012 With no grant, sram_en=0, sram_wen=0; sram_addr and sram_wdata SHALL be 0.
REQ-013 A registered owner state SHALL take the values IDLE, RESP_I, RESP_D: next owner = RESP_I on inst grant, RESP_D on data grant, else IDLE.
REQ-014 In RESP_I, inst_rvalid=1 and inst_rdata=sram_rdata SHALL hold; in RESP_D, data_rvalid=1 and data_rdata = sram_rdata for reads, 0 for writes (wen registered at grant).
REQ-015 Outside its response state, each rdata output SHALL be 0 and rvalid 0.
REQ-016 Latency SHALL be exactly one cycle grant-to-rvalid; a new grant is allowed in the same cycle as a response (throughput one access per cycle, no bubbles).
REQ-017 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, on each data grant while inst_req=1; it clears on inst grant or any cycle with inst_req=0.
REQ-018 A write followed by a read of the same address on consecutive grants SHALL return the written data (SRAM ordering, no reordering inside the block).

Reset
REQ-019 While resetn=0: owner=IDLE, starve_cnt=0, all gnt, rvalid, rdata, sram_* outputs 0, regardless of clk.
REQ-020 Reset asserted while a response is pending SHALL discard it; no rvalid appears after reset release for a pre-reset grant.
REQ-021 The first grant is possible in the first clk edge cycle after resetn rises.

Verification
REQ-022 Inst-only: inst_req=1, addr 0x1FC00000, sram returns 0x3C08BFAF -> inst_gnt same cycle, inst_rvalid next cycle with inst_rdata 0x3C08BFAF; back-to-back fetches give rvalid every cycle.
REQ-023 Collision: inst_req and data_req both 1 (data read 0x00001000) -> data_gnt=1, inst_gnt=0; next cycle data_rvalid and inst_gnt=1.
REQ-024 Starvation: inst_req held, data_req held for 10 cycles, STARVE_LIMIT=4 -> 4 data grants, then 1 inst grant, counter back to 0, repeat pattern.
REQ-025 Write then read: data write wen=4'b0011 wdata 0xAABBCCDD addr 0x2000 over prior 0x11223344 -> data_rvalid with rdata 0; subsequent read returns 0x1122CCDD.
REQ-026 Reset mid-response: grant inst, drop resetn before next edge -> all outputs 0 immediately, no inst_rvalid after release.
REQ-027 Idle: both req 0 for 5 cycles -> sram_en 0, all gnt/rvalid 0, starve_cnt 0.
